fifo_merge_arb: RTL and testbench
=================================

FIFO_MERGE_ARB -- requirements
Module: fifo_merge_arb

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 4, number of input channels (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 16, data width per channel.
REQ-003 The block SHALL have parameter DEPTH, default 8, words per channel FIFO (power of two, >=2).
REQ-004 The block SHALL have parameter ARB_MODE, default 0, with 0 = fixed priority (lowest index wins) and 1 = round-robin.
REQ-005 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have port din, input, CH_NUM*DATA_W, carrying channel i on din[i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port din_vld, input, CH_NUM, a per-channel write strobe.
REQ-009 The block SHALL have port din_full, output, CH_NUM, a per-channel FIFO-full flag.
REQ-010 The block SHALL have port dout, output, DATA_W, the merged output data.
REQ-011 The block SHALL have port dout_vld, output, 1, indicating dout/chan are valid.
REQ-012 The block SHALL have port dout_rdy, input, 1, the downstream accept signal.
REQ-013 The block SHALL have port chan, output, CH_W = clog2(CH_NUM), the source channel of dout.
REQ-014 The block SHALL have port ovf, output, CH_NUM, a per-channel sticky overflow flag.

Function
REQ-015 Channel i SHALL push din[i] when din_vld[i]=1 and din_full[i]=0.
REQ-016 A write while din_full[i]=1 SHALL be dropped and SHALL set ovf[i], which holds until reset, even if a pop of channel i occurs in the same cycle.
REQ-017 din_full[i] SHALL be 1 exactly when channel i holds DEPTH words.
REQ-018 A simultaneous push and pop on the same non-full channel SHALL leave its count unchanged, with no data loss.
REQ-019 The output register SHALL be free when dout_vld=0 or (dout_vld=1 and dout_rdy=1); an arbitration grant SHALL occur only when the register is free and at least one channel is non-empty.
REQ-020 A grant SHALL pop one word from the granted channel and load dout, chan and dout_vld=1 at the next clock edge.
REQ-021 When the register is free and no channel is non-empty, dout_vld SHALL go to 0, and dout/chan SHALL hold their last values.
REQ-022 While dout_vld=1 and dout_rdy=0, dout, chan and dout_vld SHALL remain stable, and no channel SHALL be popped.
REQ-023 Latency SHALL be as follows: for a write at edge t into an empty block with dout_rdy=1, dout_vld SHALL be 1 after edge t+1, i.e. the word is visible in the cycle following the cycle after the write.
REQ-024 Throughput SHALL be one word per cycle while dout_rdy=1 and data is pending.
REQ-025 With ARB_MODE=0, the grant SHALL go to the lowest-indexed non-empty channel.
REQ-026 With ARB_MODE=1, the search SHALL start at last_grant+1 and wrap modulo CH_NUM; last_grant SHALL update only on a grant.
REQ-027 Per-channel word order SHALL be preserved, and words SHALL never be duplicated or lost, except for the drops defined in REQ-016.

Reset
REQ-028 When rst=1 at a clock edge, all FIFOs SHALL be emptied, and dout=0, dout_vld=0, chan=0, din_full=0 and ovf=0 SHALL be set.
REQ-029 Reset SHALL set last_grant=CH_NUM-1, so that channel 0 is searched first.
REQ-030 Reset mid-operation SHALL discard all queued and in-flight words, and writes in the reset cycle SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the clog2 function and the ARB_FIXED=0/ARB_RR=1 constants.
REQ-032 A sub-module sync_fifo (DATA_W, DEPTH; push/pop/full/empty/count) SHALL be instantiated once per channel via generate.
REQ-033 The arbiter and output register SHALL be inline in fifo_merge_arb.

Verification
Configuration for all scenarios: CH_NUM=4, DATA_W=16, DEPTH=8.
REQ-034 Single word: ch2 writes 0x1234 at edge 0 with dout_rdy=1 -> after edge 1, dout=0x1234, chan=2, dout_vld=1 for exactly one cycle.
REQ-035 Fixed priority: ARB_MODE=0, all channels write 0xA000+i in the same cycle, dout_rdy=1 -> chan sequence 0,1,2,3 on consecutive cycles with the matching data.
REQ-036 Round-robin: ARB_MODE=1, ch0 and ch3 each hold 3 words, dout_rdy=1 -> chan sequence 0,3,0,3,0,3.
REQ-037 Backpressure/overflow: dout_rdy=0, ch1 writes 0x0..0x9 (10 words) -> one word enters the output register and eight queue, so din_full[1]=1 after the 9th write; the 10th write is dropped, and ovf[1]=1 from the next edge; then dout_rdy=1 -> the drain yields 0x0..0x8 in order.
REQ-038 Reset mid-operation: 3 words queued and dout_vld=1, rst pulsed for 1 cycle -> after the edge, dout_vld=0, ovf=0, din_full=0; a post-reset write of 0x55AA on ch0 appears with chan=0 and the standard latency.
REQ-039 Push/pop collision: ch3 holds 1 word and writes 0x0BEE while being popped, dout_rdy=1 -> 0x0BEE follows the held word with no gap and no loss.

Source files
------------

// File: rtl/fifo_merge_arb_pkg.sv
// Shared constants and helpers for the multi-channel FIFO merger.
package fifo_merge_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Minimum width is 1 so that degenerate sizes still give legal vectors.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/fifo_merge_arb_sync_fifo.sv
// Single-clock FIFO with show-ahead head word, full/empty flags and occupancy count.
module sync_fifo
    import fifo_merge_arb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is refused even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/fifo_merge_arb.sv
// Multi-channel FIFO merger: per-channel FIFOs drained through a fixed-priority
// or round-robin arbiter into a single registered valid/ready output.
module fifo_merge_arb
    import fifo_merge_arb_pkg::*;
#(
    parameter int CH_NUM   = 4,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int ARB_MODE = ARB_FIXED
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM*DATA_W-1:0] din,
    input  logic [CH_NUM-1:0]        din_vld,
    output logic [CH_NUM-1:0]        din_full,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_vld,
    input  logic                     dout_rdy,
    output logic [clog2(CH_NUM)-1:0] chan,
    output logic [CH_NUM-1:0]        ovf
);

    localparam int CH_W = clog2(CH_NUM);
    localparam int CW   = clog2(DEPTH + 1);

    logic [CH_NUM-1:0] full_w;
    logic [CH_NUM-1:0] empty_w;
    logic [CH_NUM-1:0] wr_en;
    logic [CH_NUM-1:0] pop_en;
    logic [DATA_W-1:0] head_w [CH_NUM];
    logic [CW-1:0]     cnt_w  [CH_NUM];

    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic              vld_q, vld_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [CH_NUM-1:0] ovf_q, ovf_d;

    logic              out_free;
    logic              found;
    logic              grant;
    logic [CH_W-1:0]   gnt_idx;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        assign wr_en[g]    = din_vld[g] & ~full_w[g];
        assign pop_en[g]   = grant && (gnt_idx == CH_W'(g));
        assign din_full[g] = (cnt_w[g] == CW'(DEPTH));

        sync_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (wr_en[g]),
            .pop_i   (pop_en[g]),
            .din_i   (din[g*DATA_W +: DATA_W]),
            .dout_o  (head_w[g]),
            .full_o  (full_w[g]),
            .empty_o (empty_w[g]),
            .count_o (cnt_w[g])
        );
    end

    assign out_free = !vld_q || dout_rdy;

    // Round-robin: first pass covers channels above last grant, second pass wraps
    // around; fixed priority simply takes the first non-empty channel.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (!found && !empty_w[CH_W'(k)] &&
                (ARB_MODE == ARB_FIXED || CH_W'(k) > last_q)) begin
                found   = 1'b1;
                gnt_idx = CH_W'(k);
            end
        end
        for (int k = 0; k < CH_NUM; k++) begin
            if (!found && !empty_w[CH_W'(k)]) begin
                found   = 1'b1;
                gnt_idx = CH_W'(k);
            end
        end
    end

    assign grant = out_free && found;

    always_comb begin
        dout_d = dout_q;
        chan_d = chan_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (grant) begin
            dout_d = head_w[gnt_idx];
            chan_d = gnt_idx;
            vld_d  = 1'b1;
            last_d = gnt_idx;
        end else if (out_free) begin
            vld_d  = 1'b0;
        end
        ovf_d = ovf_q | (din_vld & full_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            chan_q <= '0;
            vld_q  <= 1'b0;
            last_q <= CH_W'(CH_NUM - 1);
            ovf_q  <= '0;
        end else begin
            dout_q <= dout_d;
            chan_q <= chan_d;
            vld_q  <= vld_d;
            last_q <= last_d;
            ovf_q  <= ovf_d;
        end
    end

    assign dout     = dout_q;
    assign chan     = chan_q;
    assign dout_vld = vld_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_fifo_merge_arb.sv
// Bench for fifo_merge_arb: fixed-priority and round-robin instances share stimulus
// and are checked against a queue-based model, directed vectors and hand sequences.
module tb_fifo_merge_arb;

    localparam int CH    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [CH*DW-1:0]  din;
    logic [CH-1:0]     din_vld;
    logic              dout_rdy;

    logic [CH-1:0]     full0, ovf0, full1, ovf1;
    logic [DW-1:0]     dout0, dout1;
    logic              vld0, vld1;
    logic [1:0]        chan0, chan1;

    fifo_merge_arb #(.CH_NUM(CH), .DATA_W(DW), .DEPTH(DEPTH), .ARB_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_full(full0),
        .dout(dout0), .dout_vld(vld0), .dout_rdy(dout_rdy), .chan(chan0), .ovf(ovf0)
    );

    fifo_merge_arb #(.CH_NUM(CH), .DATA_W(DW), .DEPTH(DEPTH), .ARB_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_full(full1),
        .dout(dout1), .dout_vld(vld1), .dout_rdy(dout_rdy), .chan(chan1), .ovf(ovf1)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model, index m: 0 = fixed priority, 1 = round-robin.
    logic [DW-1:0] mq [8][$];
    bit            m_vld  [2];
    logic [DW-1:0] m_dout [2];
    int            m_chan [2];
    logic [CH-1:0] m_ovf  [2];
    int            m_last [2];

    typedef struct {
        bit            r;
        logic [63:0]   d;
        logic [3:0]    v;
        bit            rdy;
        bit            e_vld;
        logic [15:0]   e_dout;
        logic [1:0]    e_chan;
        logic [3:0]    e_full;
        logic [3:0]    e_ovf;
    } vec_t;

    vec_t tv[$];

    function automatic logic [63:0] pk(int ch, logic [15:0] val);
        logic [63:0] w;
        w = '0;
        w[ch*16 +: 16] = val;
        return w;
    endfunction

    task automatic model_step(int m, bit r, logic [63:0] d, logic [3:0] v, bit rdy);
        int  sz [4];
        int  g;
        int  c;
        bit  free;
        if (r) begin
            for (int i = 0; i < CH; i++) mq[m*4+i].delete();
            m_vld[m]  = 1'b0;
            m_dout[m] = '0;
            m_chan[m] = 0;
            m_ovf[m]  = '0;
            m_last[m] = CH - 1;
            return;
        end
        for (int i = 0; i < CH; i++) sz[i] = mq[m*4+i].size();
        free = !m_vld[m] || rdy;
        g = -1;
        if (free) begin
            for (int k = 0; k < CH; k++) begin
                c = (m == 1) ? (m_last[m] + 1 + k) % CH : k;
                if (g < 0 && sz[c] > 0) g = c;
            end
        end
        if (g >= 0) begin
            m_dout[m] = mq[m*4+g].pop_front();
            m_chan[m] = g;
            m_vld[m]  = 1'b1;
            m_last[m] = g;
        end else if (free) begin
            m_vld[m] = 1'b0;
        end
        for (int i = 0; i < CH; i++) begin
            if (v[i]) begin
                if (sz[i] < DEPTH) mq[m*4+i].push_back(d[i*16 +: 16]);
                else m_ovf[m][i] = 1'b1;
            end
        end
    endtask

    function automatic logic [26:0] mexp(int m);
        logic [3:0] f;
        for (int i = 0; i < CH; i++) f[i] = (mq[m*4+i].size() == DEPTH);
        return {m_vld[m], m_dout[m], 2'(m_chan[m]), f, m_ovf[m]};
    endfunction

    task automatic chk(string name, logic [26:0] act, logic [26:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got vld=%0b dout=%h chan=%0d full=%b ovf=%b, expected vld=%0b dout=%h chan=%0d full=%b ovf=%b",
                     name, act[26], act[25:10], act[9:8], act[7:4], act[3:0],
                     exp[26], exp[25:10], exp[9:8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic step(bit r, logic [63:0] d, logic [3:0] v, bit rdy, string tag);
        rst      = r;
        din      = d;
        din_vld  = v;
        dout_rdy = rdy;
        @(posedge clk);
        #1;
        model_step(0, r, d, v, rdy);
        model_step(1, r, d, v, rdy);
        chk({tag, "/fixed"}, {vld0, dout0, chan0, full0, ovf0}, mexp(0));
        chk({tag, "/rr"},    {vld1, dout1, chan1, full1, ovf1}, mexp(1));
    endtask

    task automatic add(bit r, logic [63:0] d, logic [3:0] v, bit rdy,
                       bit ev, logic [15:0] ed, logic [1:0] ec, logic [3:0] ef, logic [3:0] eo);
        vec_t t;
        t.r = r; t.d = d; t.v = v; t.rdy = rdy;
        t.e_vld = ev; t.e_dout = ed; t.e_chan = ec; t.e_full = ef; t.e_ovf = eo;
        tv.push_back(t);
    endtask

    logic [15:0] rr_data [5];
    logic [1:0]  rr_chan [5];
    int          rdy_pct [4];

    initial begin
        rst = 1'b1; din = '0; din_vld = '0; dout_rdy = 1'b1;

        // Reset, single word on ch2.
        add(1, 0, 4'b0000, 1, 0, 16'h0000, 0, 4'b0, 4'b0);
        add(0, pk(2, 16'h1234), 4'b0100, 1, 0, 16'h0000, 0, 4'b0, 4'b0);
        add(0, 0, 4'b0000, 1, 1, 16'h1234, 2, 4'b0, 4'b0);
        add(0, 0, 4'b0000, 1, 0, 16'h1234, 2, 4'b0, 4'b0);
        // All channels at once: fixed priority drains 0,1,2,3.
        add(0, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 4'b1111, 1, 0, 16'h1234, 2, 4'b0, 4'b0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 4'b0000, 1, 1, 16'(16'hA000 + i), 2'(i), 4'b0, 4'b0);
        add(0, 0, 4'b0000, 1, 0, 16'hA003, 3, 4'b0, 4'b0);
        // Push/pop collision on ch3.
        add(0, pk(3, 16'h0111), 4'b1000, 1, 0, 16'hA003, 3, 4'b0, 4'b0);
        add(0, pk(3, 16'h0BEE), 4'b1000, 1, 1, 16'h0111, 3, 4'b0, 4'b0);
        add(0, 0, 4'b0000, 1, 1, 16'h0BEE, 3, 4'b0, 4'b0);
        add(0, 0, 4'b0000, 1, 0, 16'h0BEE, 3, 4'b0, 4'b0);
        // Backpressure and overflow on ch1.
        add(0, pk(1, 16'h0000), 4'b0010, 0, 0, 16'h0BEE, 3, 4'b0, 4'b0);
        for (int k = 1; k <= 7; k++)
            add(0, pk(1, 16'(k)), 4'b0010, 0, 1, 16'h0000, 1, 4'b0, 4'b0);
        add(0, pk(1, 16'h0008), 4'b0010, 0, 1, 16'h0000, 1, 4'b0010, 4'b0);
        add(0, pk(1, 16'h0009), 4'b0010, 0, 1, 16'h0000, 1, 4'b0010, 4'b0010);
        for (int j = 1; j <= 8; j++)
            add(0, 0, 4'b0000, 1, 1, 16'(j), 1, 4'b0, 4'b0010);
        add(0, 0, 4'b0000, 1, 0, 16'h0008, 1, 4'b0, 4'b0010);
        // Reset mid-operation with a write during the reset cycle.
        add(0, pk(0, 16'hE000), 4'b0001, 0, 0, 16'h0008, 1, 4'b0, 4'b0010);
        for (int k = 1; k <= 3; k++)
            add(0, pk(0, 16'(16'hE000 + k)), 4'b0001, 0, 1, 16'hE000, 0, 4'b0, 4'b0010);
        add(1, pk(2, 16'h7777), 4'b0100, 0, 0, 16'h0000, 0, 4'b0, 4'b0);
        add(0, pk(0, 16'h55AA), 4'b0001, 1, 0, 16'h0000, 0, 4'b0, 4'b0);
        add(0, 0, 4'b0000, 1, 1, 16'h55AA, 0, 4'b0, 4'b0);
        add(0, 0, 4'b0000, 1, 0, 16'h55AA, 0, 4'b0, 4'b0);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].r, tv[i].d, tv[i].v, tv[i].rdy, $sformatf("model_v%0d", i));
            chk($sformatf("vec%0d", i), {vld0, dout0, chan0, full0, ovf0},
                {tv[i].e_vld, tv[i].e_dout, tv[i].e_chan, tv[i].e_full, tv[i].e_ovf});
        end

        // Round-robin: ch0 and ch3 hold 3 words each, expect 0,3,0,3,0,3.
        step(1, 0, 4'b0000, 1, "rr_rst");
        for (int k = 0; k < 3; k++) begin
            step(0, pk(0, 16'(16'hC000 + k)) | pk(3, 16'(16'hD000 + k)), 4'b1001, 0, "rr_fill");
            if (k == 0) chk("rr_fill0", {vld1, dout1, chan1, full1, ovf1}, {1'b0, 16'h0000, 2'd0, 4'b0, 4'b0});
            else        chk("rr_fill",  {vld1, dout1, chan1, full1, ovf1}, {1'b1, 16'hC000, 2'd0, 4'b0, 4'b0});
        end
        rr_data[0] = 16'hD000; rr_chan[0] = 2'd3;
        rr_data[1] = 16'hC001; rr_chan[1] = 2'd0;
        rr_data[2] = 16'hD001; rr_chan[2] = 2'd3;
        rr_data[3] = 16'hC002; rr_chan[3] = 2'd0;
        rr_data[4] = 16'hD002; rr_chan[4] = 2'd3;
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 4'b0000, 1, "rr_drain");
            chk($sformatf("rr_seq%0d", k), {vld1, dout1, chan1, full1, ovf1},
                {1'b1, rr_data[k], rr_chan[k], 4'b0, 4'b0});
        end
        step(0, 0, 4'b0000, 1, "rr_idle");
        chk("rr_end", {vld1, dout1, chan1, full1, ovf1}, {1'b0, 16'hD002, 2'd3, 4'b0, 4'b0});

        // Randomized traffic with varying backpressure and rare resets.
        rdy_pct[0] = 90; rdy_pct[1] = 50; rdy_pct[2] = 15; rdy_pct[3] = 100;
        step(1, 0, 4'b0000, 1, "rnd_rst");
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 600; n++) begin
                logic [63:0] d;
                logic [3:0]  v;
                bit          r;
                bit          rdy;
                d   = {$urandom, $urandom};
                v   = 4'($urandom_range(0, 15));
                if (ph == 3) v = v & 4'($urandom_range(0, 15));
                r   = ($urandom_range(0, 299) == 0);
                rdy = ($urandom_range(0, 99) < rdy_pct[ph]);
                step(r, d, v, rdy, $sformatf("rnd_p%0d", ph));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
